spi_xfer_arbiter: RTL and testbench
===================================

# spi_xfer_arbiter

Round-robin arbiter and transaction sequencer that shares one SPI byte engine (the `spi` core inside the Wishbone SPI master) between several requesters, e.g. the Wishbone register front end and an autonomous sensor poller. Each accepted request is a two-byte transfer: an address byte, then either a write-data byte or a read phase. The block drives the engine's phase controls and chip enable, and returns read data or a timeout error to the owning requester.

## Interface
- `N_REQ`, 2: number of requesters, range 2..4.
- `GAP_CYCLES`, 20: idle cycles between the address byte and the read phase, with CE held.
- `TIMEOUT_CYCLES`, 4095: maximum cycles spent in any engine phase before the transfer is aborted.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in N_REQ: per-requester transfer request; held until accepted.
- `req_ready` out N_REQ: one-hot acceptance pulse.
- `req_we` in N_REQ: 1 = write transfer, 0 = read transfer.
- `req_addr` in 8*N_REQ: address byte; requester i uses bits [8i+7:8i].
- `req_wdata` in 8*N_REQ: write byte, packed the same way.
- `rsp_valid` out N_REQ: one-hot, one-cycle completion pulse.
- `rsp_err` out 1: qualifies `rsp_valid`; 1 = timeout abort.
- `rsp_rdata` out 8: read byte; valid with `rsp_valid` on a successful read, 0 otherwise.
- `eng_write` out 1: engine write-phase enable.
- `eng_read` out 1: engine read-phase enable.
- `eng_begin_sck` out 1: engine SCK run enable.
- `eng_byte` out 8: byte presented to the engine.
- `eng_write_done` in 1: engine byte-sent pulse.
- `eng_read_done` in 1: engine byte-received pulse.
- `eng_rdata` in 8: engine received byte.
- `ce` out 1: chip enable, active-high.
- `busy` out 1: high whenever the state is not IDLE.
- `grant_id` out 2: index of the current owner; holds its last value while in IDLE.

## Operation
- States: IDLE, ADDR, DATA_WR, GAP, DATA_RD, DONE.
- IDLE:
  - If any `req_valid` is set, grant the first valid index at or after `rr_ptr`, searching modulo N_REQ.
  - Pulse `req_ready[g]`, latch `we`, `addr` and `wdata`, set `grant_id` = g, set `rr_ptr` = (g+1) mod N_REQ, go to ADDR.
- ADDR:
  - `ce`=1, `eng_write`=1, `eng_begin_sck`=1, `eng_byte`=addr.
  - On `eng_write_done`: go to DATA_WR if we, otherwise to GAP.
- DATA_WR:
  - `ce`=1, `eng_write`=1, `eng_begin_sck`=1, `eng_byte`=wdata.
  - On `eng_write_done`: go to DONE.
- GAP:
  - `ce`=1, `eng_begin_sck`=0, `eng_byte`=0, gap counter increments.
  - After exactly GAP_CYCLES cycles in GAP, go to DATA_RD.
- DATA_RD:
  - `ce`=1, `eng_read`=1, `eng_begin_sck`=1.
  - On `eng_read_done`: capture `eng_rdata`, go to DONE.
- DONE:
  - `ce`=0, engine controls 0, pulse `rsp_valid[grant_id]`, return to IDLE.
- Timeout:
  - A watchdog is cleared on every state entry and counts in ADDR, DATA_WR and DATA_RD.
  - On reaching TIMEOUT_CYCLES it forces DONE with `rsp_err`=1 and `rsp_rdata`=0.
- Done pulses arriving in a state that does not expect them are ignored (for example `eng_read_done` during ADDR).
- Engine controls and `ce` are decoded combinationally from the state. `rsp_*`, `req_ready` and all counters are registered.

## Timing
- Reset values: all outputs 0, `rr_ptr`=0, state IDLE, all counters 0.
- Reset mid-transfer: the transfer is dropped with no `rsp_valid`, and `ce` falls on the first cycle of reset.
- Arbitration latency: a request seen in IDLE in cycle t gets `req_ready` in cycle t, is latched at the end of t, and ADDR starts in t+1.
- Back-to-back: after DONE there is one IDLE cycle before the next grant, so CE is low for at least 2 cycles between transfers.
- A done pulse in cycle t moves the state in t+1. The watchdog compare uses the count before increment. The gap counter is 5-bit minimum and sized with $clog2.
- A requester must hold `req_valid` and its data stable until `req_ready`. Dropping `req_valid` early is legal and the request is simply not granted.
- Simultaneous `req_valid` from all requesters: grants rotate strictly, e.g. 0,1,0,1 for N_REQ=2, with no starvation.

## Structure
- Shared package `spi_pkg`:
  - State enum with the encodings IDLE=0, ADDR=1, DATA_WR=2, GAP=3, DATA_RD=4, DONE=5.
  - Default constants for GAP_CYCLES and TIMEOUT_CYCLES.
- One sub-module, `rr_arbiter`: combinational priority search taking req, ptr and N_REQ and producing a one-hot grant plus its index.
- Instantiated beside `spi`; the Wishbone SPI master becomes requester 0.

## Test plan
- Write: requester 0 issues we=1, addr=0x2A, wdata=0x5C. Expect `eng_byte` 0x2A then 0x5C, `ce` high throughout, `rsp_valid[0]` with err=0.
- Read: requester 1 issues we=0, addr=0x8F, with the engine model returning 0xA5. Expect exactly 20 GAP cycles with SCK disabled, then `rsp_rdata`=0xA5 on `rsp_valid[1]`.
- Contention: both requesters hold valid for 4 transfers. Expect grant order 0,1,0,1 and each `rsp_valid` routed to the correct index.
- Timeout: suppress `eng_write_done` with TIMEOUT_CYCLES=100. Expect DONE after 100 ADDR cycles with `rsp_err`=1, `rsp_rdata`=0, then `ce`=0.
- Reset during DATA_RD: expect all outputs 0 on the next edge, no `rsp_valid`, and the next grant going to requester 0.
- Stray pulse: `eng_read_done` during ADDR must not advance the state, and `eng_byte` stays 0x2A.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transfer arbiter.
package spi_pkg;

  // Transfer sequencer states, fixed encodings.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    DATA_WR = 3'd2,
    GAP     = 3'd3,
    DATA_RD = 3'd4,
    DONE    = 3'd5
  } xfer_state_e;

  localparam int DEF_GAP_CYCLES     = 20;
  localparam int DEF_TIMEOUT_CYCLES = 4095;

  // Gap counter width: enough to hold the gap length, never narrower than 5 bits.
  function automatic int gap_cnt_width(input int gap_cycles);
    int w;
    w = $clog2(gap_cycles + 1);
    return (w < 5) ? 5 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [1:0]       idx_o,
  output logic             any_o
);

  // Walk candidates in rotated order; the first valid one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!any_o && req_i[i] && (i == ((int'(ptr_i) + k) % N_REQ))) begin
          gnt_o[i] = 1'b1;
          idx_o    = 2'(i);
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI byte engine between N_REQ requesters. Each grant runs an
// address byte followed by either a write byte or a gap plus read byte.
//
// state   | meaning
// IDLE    | no owner, arbitrate among valid requests
// ADDR    | shifting the address byte
// DATA_WR | shifting the write-data byte
// GAP     | CE held, SCK stopped, waiting GAP_CYCLES before the read
// DATA_RD | receiving the read byte
// DONE    | CE low, completion pulse to the owner
module spi_xfer_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_we,
  input  logic [8*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic               rsp_err,
  output logic [7:0]         rsp_rdata,
  output logic               eng_write,
  output logic               eng_read,
  output logic               eng_begin_sck,
  output logic [7:0]         eng_byte,
  input  logic               eng_write_done,
  input  logic               eng_read_done,
  input  logic [7:0]         eng_rdata,
  output logic               ce,
  output logic               busy,
  output logic [1:0]         grant_id
);

  localparam int GAP_W = gap_cnt_width(GAP_CYCLES);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  xfer_state_e state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       grant_id_q;
  logic             we_q;
  logic [7:0]       addr_q, wdata_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic             rsp_err_q;
  logic [7:0]       rsp_rdata_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [1:0]       arb_idx;
  logic             arb_any;
  logic             grant_fire;
  logic             abort;
  logic             gap_hit, wd_hit;
  logic             sel_we;
  logic [7:0]       sel_addr, sel_wdata;
  logic [N_REQ-1:0] owner_oh;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Ready is a same-cycle acknowledge so the request is latched in the cycle it is granted.
  assign grant_fire = (state_q == IDLE) && arb_any && !reset;
  assign req_ready  = grant_fire ? arb_gnt : '0;

  assign gap_hit = (gap_q == GAP_W'(GAP_CYCLES - 1));
  assign wd_hit  = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Select the granted requester's fields and the owner's one-hot response lane.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    owner_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_idx == 2'(i)) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[8*i +: 8];
        sel_wdata = req_wdata[8*i +: 8];
      end
      owner_oh[i] = (grant_id_q == 2'(i));
    end
  end

  // Next-state and engine/CE decode from the current state.
  always_comb begin
    state_d       = state_q;
    abort         = 1'b0;
    ce            = 1'b0;
    eng_write     = 1'b0;
    eng_read      = 1'b0;
    eng_begin_sck = 1'b0;
    eng_byte      = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) state_d = ADDR;
      end
      ADDR: begin
        ce            = 1'b1;
        eng_write     = 1'b1;
        eng_begin_sck = 1'b1;
        eng_byte      = addr_q;
        if (eng_write_done) begin
          state_d = we_q ? DATA_WR : GAP;
        end else if (wd_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      DATA_WR: begin
        ce            = 1'b1;
        eng_write     = 1'b1;
        eng_begin_sck = 1'b1;
        eng_byte      = wdata_q;
        if (eng_write_done) begin
          state_d = DONE;
        end else if (wd_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      GAP: begin
        ce = 1'b1;
        if (gap_hit) state_d = DATA_RD;
      end
      DATA_RD: begin
        ce            = 1'b1;
        eng_read      = 1'b1;
        eng_begin_sck = 1'b1;
        if (eng_read_done) begin
          state_d = DONE;
        end else if (wd_hit) begin
          state_d = DONE;
          abort   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Drop CE and the engine controls in the very first reset cycle, not one later.
    if (reset) begin
      ce            = 1'b0;
      eng_write     = 1'b0;
      eng_read      = 1'b0;
      eng_begin_sck = 1'b0;
      eng_byte      = '0;
    end
  end

  // Counters restart on every state entry; the watchdog only runs in engine phases.
  always_comb begin
    gap_d  = ((state_q == GAP) && (state_d == GAP)) ? gap_q + 1'b1 : '0;
    wdog_d = ((state_d == state_q) &&
              ((state_q == ADDR) || (state_q == DATA_WR) || (state_q == DATA_RD)))
             ? wdog_q + 1'b1 : '0;
  end

  // State, counters, request latch and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      wdog_q      <= '0;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      wdog_q  <= wdog_d;
      if (grant_fire) begin
        we_q       <= sel_we;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        grant_id_q <= arb_idx;
        rr_ptr_q   <= (arb_idx == 2'(N_REQ - 1)) ? 2'd0 : arb_idx + 2'd1;
      end
      rsp_valid_q <= ((state_d == DONE) && (state_q != DONE)) ? owner_oh : '0;
      rsp_err_q   <= abort;
      rsp_rdata_q <= ((state_q == DATA_RD) && eng_read_done) ? eng_rdata : '0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter: write, read with gap, contention,
// watchdog abort, reset mid-read and a stray done pulse.
module tb_spi_xfer_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  logic        eng_write;
  logic        eng_read;
  logic        eng_begin_sck;
  logic [7:0]  eng_byte;
  logic        eng_write_done;
  logic        eng_read_done;
  logic [7:0]  eng_rdata;
  logic        ce;
  logic        busy;
  logic [1:0]  grant_id;

  int vectors;
  int miscompares;
  int n;

  spi_xfer_arbiter #(
    .N_REQ          (2),
    .GAP_CYCLES     (20),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_err        (rsp_err),
    .rsp_rdata      (rsp_rdata),
    .eng_write      (eng_write),
    .eng_read       (eng_read),
    .eng_begin_sck  (eng_begin_sck),
    .eng_byte       (eng_byte),
    .eng_write_done (eng_write_done),
    .eng_read_done  (eng_read_done),
    .eng_rdata      (eng_rdata),
    .ce             (ce),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b1;
    req_valid      = '0;
    req_we         = '0;
    req_addr       = '0;
    req_wdata      = '0;
    eng_write_done = 1'b0;
    eng_read_done  = 1'b0;
    eng_rdata      = '0;

    // Reset state
    repeat (3) cyc();
    #1;
    chk("rst_busy",      32'(busy),      0);
    chk("rst_ce",        32'(ce),        0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_grant_id",  32'(grant_id),  0);
    chk("rst_eng_byte",  32'(eng_byte),  0);
    reset = 1'b0;
    cyc();

    // Write from requester 0, with a stray read-done while in ADDR
    req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h002A; req_wdata = 16'h005C;
    #1;
    chk("wr_ready", 32'(req_ready), 'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("wr_addr_byte", 32'(eng_byte), 'h2A);
    chk("wr_addr_ce",   32'(ce),       1);
    chk("wr_grant",     32'(grant_id), 0);
    eng_read_done = 1'b1;
    cyc();
    eng_read_done = 1'b0;
    #1;
    chk("stray_byte",  32'(eng_byte),  'h2A);
    chk("stray_write", 32'(eng_write), 1);
    chk("stray_read",  32'(eng_read),  0);
    eng_write_done = 1'b1;
    cyc();
    eng_write_done = 1'b0;
    #1;
    chk("wr_data_byte", 32'(eng_byte), 'h5C);
    chk("wr_data_ce",   32'(ce),       1);
    eng_write_done = 1'b1;
    cyc();
    eng_write_done = 1'b0;
    #1;
    chk("wr_rsp_valid", 32'(rsp_valid), 'h1);
    chk("wr_rsp_err",   32'(rsp_err),   0);
    chk("wr_done_ce",   32'(ce),        0);
    cyc();
    #1;
    chk("wr_idle_rsp",  32'(rsp_valid), 0);
    chk("wr_idle_busy", 32'(busy),      0);

    // Read from requester 1 with a 20-cycle gap
    req_valid = 2'b10; req_we = 2'b00; req_addr = 16'h8F00;
    #1;
    chk("rd_ready", 32'(req_ready), 'h2);
    cyc();
    req_valid = '0;
    #1;
    chk("rd_addr_byte", 32'(eng_byte), 'h8F);
    chk("rd_grant",     32'(grant_id), 1);
    eng_write_done = 1'b1;
    cyc();
    eng_write_done = 1'b0;
    #1;
    chk("gap_byte", 32'(eng_byte),      0);
    chk("gap_sck",  32'(eng_begin_sck), 0);
    chk("gap_ce",   32'(ce),            1);
    n = 0;
    while (ce && !eng_begin_sck && n < 100) begin
      n++;
      cyc();
      #1;
    end
    chk("gap_len",   32'(n),             20);
    chk("rd_eng_rd", 32'(eng_read),      1);
    chk("rd_sck",    32'(eng_begin_sck), 1);
    eng_rdata = 8'hA5; eng_read_done = 1'b1;
    cyc();
    eng_read_done = 1'b0; eng_rdata = '0;
    #1;
    chk("rd_rsp_valid", 32'(rsp_valid), 'h2);
    chk("rd_rsp_rdata", 32'(rsp_rdata), 'hA5);
    chk("rd_rsp_err",   32'(rsp_err),   0);
    cyc();

    // Contention: both hold valid for four write transfers
    req_valid = 2'b11; req_we = 2'b11; req_addr = 16'hB1A0; req_wdata = 16'h2211;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 10) begin
        n++;
        cyc();
        #1;
      end
      chk("cont_ready",   32'(req_ready), (k % 2) ? 'h2 : 'h1);
      chk("cont_idle_ce", 32'(ce),        0);
      cyc();
      #1;
      chk("cont_grant", 32'(grant_id), k % 2);
      chk("cont_byte",  32'(eng_byte), (k % 2) ? 'hB1 : 'hA0);
      eng_write_done = 1'b1;
      cyc();
      cyc();
      eng_write_done = 1'b0;
      #1;
      chk("cont_rsp", 32'(rsp_valid), (k % 2) ? 'h2 : 'h1);
      cyc();
      #1;
    end
    req_valid = '0;

    // Watchdog: no write-done, abort after 100 ADDR cycles
    req_valid = 2'b01; req_we = 2'b01; req_addr = 16'h0011;
    #1;
    chk("to_ready", 32'(req_ready), 'h1);
    cyc();
    req_valid = '0;
    #1;
    n = 0;
    while (eng_write && n < 200) begin
      n++;
      cyc();
      #1;
    end
    chk("to_len",   32'(n),         100);
    chk("to_rsp",   32'(rsp_valid), 'h1);
    chk("to_err",   32'(rsp_err),   1);
    chk("to_rdata", 32'(rsp_rdata), 0);
    chk("to_ce",    32'(ce),        0);
    cyc();
    #1;
    chk("to_idle", 32'(busy), 0);

    // Reset during DATA_RD from requester 1
    req_valid = 2'b10; req_we = 2'b00; req_addr = 16'h3300;
    cyc();
    req_valid = '0;
    eng_write_done = 1'b1;
    cyc();
    eng_write_done = 1'b0;
    #1;
    n = 0;
    while (!eng_read && n < 100) begin
      n++;
      cyc();
      #1;
    end
    chk("rr_in_read", 32'(eng_read), 1);
    reset = 1'b1;
    #1;
    chk("rr_ce_now", 32'(ce), 0);
    cyc();
    #1;
    chk("rr_busy",  32'(busy),      0);
    chk("rr_grant", 32'(grant_id),  0);
    chk("rr_rsp",   32'(rsp_valid), 0);
    chk("rr_read",  32'(eng_read),  0);
    cyc();
    #1;
    chk("rr_rsp2", 32'(rsp_valid), 0);
    reset = 1'b0;
    req_valid = 2'b11; req_we = 2'b00;
    #1;
    chk("rr_next_ready", 32'(req_ready), 'h1);
    cyc();
    req_valid = '0;
    #1;
    chk("rr_next_grant", 32'(grant_id), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
